// File: rtl/rr_crossbar.sv
// PORT_N x PORT_N crossbar: per-output round-robin arbiter feeding a one-entry
// registered output stage, with valid/ready flow control on both sides.
module rr_crossbar #(
    parameter int DATA_WIDTH = 8,
    parameter int PORT_N     = 5,
    parameter int DST_WIDTH  = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [PORT_N*DATA_WIDTH-1:0] data_i,
    input  logic [PORT_N-1:0]            vld_i,
    input  logic [PORT_N*DST_WIDTH-1:0]  dst_i,
    output logic [PORT_N-1:0]            rdy_o,
    output logic [PORT_N*DATA_WIDTH-1:0] data_o,
    output logic [PORT_N-1:0]            vld_o,
    input  logic [PORT_N-1:0]            rdy_i,
    output logic                         drop_o
);

    localparam int PW = (PORT_N > 1) ? $clog2(PORT_N) : 1;

    logic [PW-1:0]         ptr_q    [PORT_N];
    logic [PW-1:0]         ptr_nxt  [PORT_N];
    logic [PW-1:0]         gnt_idx  [PORT_N];
    logic [DATA_WIDTH-1:0] data_q   [PORT_N];
    logic [PORT_N-1:0]     gnt_vld;
    logic [PORT_N-1:0]     free;
    logic [PORT_N-1:0]     drop_req;
    logic [PORT_N-1:0]     accept;
    logic [PORT_N-1:0]     vld_q;
    logic                  drop_q;
    int                    dst_int  [PORT_N];

    always_comb begin
        for (int k = 0; k < PORT_N; k++) begin
            dst_int[k]  = int'(dst_i[k*DST_WIDTH +: DST_WIDTH]);
            drop_req[k] = vld_i[k] && (dst_int[k] >= PORT_N);
        end
    end

    // Search starts at the pointer and wraps; only a free output may grant.
    always_comb begin
        int idx;
        idx = 0;
        for (int j = 0; j < PORT_N; j++) begin
            free[j]    = !vld_q[j] || rdy_i[j];
            gnt_vld[j] = 1'b0;
            gnt_idx[j] = '0;
            for (int off = 0; off < PORT_N; off++) begin
                idx = (int'(ptr_q[j]) + off) % PORT_N;
                if (!gnt_vld[j] && free[j] && vld_i[idx] && (dst_int[idx] == j)) begin
                    gnt_vld[j] = 1'b1;
                    gnt_idx[j] = PW'(idx);
                end
            end
            ptr_nxt[j] = PW'((int'(gnt_idx[j]) + 1) % PORT_N);
        end
    end

    always_comb begin
        for (int k = 0; k < PORT_N; k++) begin
            accept[k] = 1'b0;
            for (int j = 0; j < PORT_N; j++) begin
                if (gnt_vld[j] && (int'(gnt_idx[j]) == k)) begin
                    accept[k] = 1'b1;
                end
            end
        end
    end

    assign rdy_o = rst_ni ? (accept | drop_req) : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            drop_q <= 1'b0;
            for (int j = 0; j < PORT_N; j++) begin
                data_q[j] <= '0;
                ptr_q[j]  <= '0;
            end
        end else begin
            drop_q <= |drop_req;
            for (int j = 0; j < PORT_N; j++) begin
                if (gnt_vld[j]) begin
                    data_q[j] <= data_i[int'(gnt_idx[j])*DATA_WIDTH +: DATA_WIDTH];
                    vld_q[j]  <= 1'b1;
                    ptr_q[j]  <= ptr_nxt[j];
                end else if (rdy_i[j]) begin
                    vld_q[j]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < PORT_N; j++) begin
            data_o[j*DATA_WIDTH +: DATA_WIDTH] = data_q[j];
        end
    end

    assign vld_o  = vld_q;
    assign drop_o = drop_q;

endmodule

// File: tb/tb_rr_crossbar.sv
// Self-checking bench for rr_crossbar: directed scenarios plus random traffic
// compared against a behavioural model of the arbitration rules.
module tb_rr_crossbar;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam int SW = 3;

    logic              clk;
    logic              rst_n;
    logic [N*DW-1:0]   data_i;
    logic [N-1:0]      vld_i;
    logic [N*SW-1:0]   dst_i;
    logic [N-1:0]      rdy_o;
    logic [N*DW-1:0]   data_o;
    logic [N-1:0]      vld_o;
    logic [N-1:0]      rdy_i;
    logic              drop_o;

    int errs;
    int checks;

    // Model state
    int           m_ptr  [N];
    logic         m_vld  [N];
    logic [DW-1:0] m_data [N];
    logic         m_drop;
    int           m_gnt  [N];
    logic [N-1:0] m_rdy;

    rr_crossbar #(.DATA_WIDTH(DW), .PORT_N(N), .DST_WIDTH(SW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .data_i (data_i),
        .vld_i  (vld_i),
        .dst_i  (dst_i),
        .rdy_o  (rdy_o),
        .data_o (data_o),
        .vld_o  (vld_o),
        .rdy_i  (rdy_i),
        .drop_o (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dst_of(input int k);
        return int'(dst_i[k*SW +: SW]);
    endfunction

    function automatic logic [DW-1:0] out_data(input int j);
        return data_o[j*DW +: DW];
    endfunction

    function automatic logic [N-1:0] m_vld_vec();
        logic [N-1:0] v;
        for (int j = 0; j < N; j++) v[j] = m_vld[j];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] m_data_vec();
        logic [N*DW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = m_data[j];
        return v;
    endfunction

    task automatic m_reset();
        for (int j = 0; j < N; j++) begin
            m_ptr[j]  = 0;
            m_vld[j]  = 1'b0;
            m_data[j] = '0;
        end
        m_drop = 1'b0;
    endtask

    // Expected grants and input readiness from the current inputs.
    task automatic m_arb();
        m_rdy = '0;
        for (int j = 0; j < N; j++) begin
            m_gnt[j] = -1;
            if (!m_vld[j] || rdy_i[j]) begin
                for (int off = 0; off < N; off++) begin
                    int k;
                    k = (m_ptr[j] + off) % N;
                    if (m_gnt[j] < 0 && vld_i[k] && dst_of(k) == j) m_gnt[j] = k;
                end
            end
            if (m_gnt[j] >= 0) m_rdy[m_gnt[j]] = 1'b1;
        end
        for (int k = 0; k < N; k++)
            if (vld_i[k] && dst_of(k) >= N) m_rdy[k] = 1'b1;
        if (!rst_n) m_rdy = '0;
    endtask

    task automatic m_edge();
        m_drop = 1'b0;
        for (int k = 0; k < N; k++)
            if (vld_i[k] && dst_of(k) >= N) m_drop = 1'b1;
        for (int j = 0; j < N; j++) begin
            if (m_gnt[j] >= 0) begin
                m_data[j] = data_i[m_gnt[j]*DW +: DW];
                m_vld[j]  = 1'b1;
                m_ptr[j]  = (m_gnt[j] + 1) % N;
            end else if (rdy_i[j]) begin
                m_vld[j] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        m_arb();
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_edge();
        #1;
    endtask

    task automatic set_in(input int k, input logic v, input int d, input logic [DW-1:0] x);
        vld_i[k]            = v;
        dst_i[k*SW +: SW]   = SW'(d);
        data_i[k*DW +: DW]  = x;
    endtask

    task automatic clear_in();
        vld_i  = '0;
        dst_i  = '0;
        data_i = '0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy_i = '1;
        for (int k = 0; k < N; k++) set_in(k, 1'b1, k, 8'(k + 1));
        #1;
        checks++;
        if (rdy_o !== '0) begin
            errs++;
            $display("FAIL reset_rdy: got %b expected %b", rdy_o, 5'b0);
        end
        tick();
        checks++;
        if (vld_o !== '0 || data_o !== '0 || drop_o !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: got vld=%b data=%h drop=%b expected all zero", vld_o, data_o, drop_o);
        end
        clear_in();
        rst_n = 1'b1;
    endtask

    task automatic test_single_path();
        clear_in();
        rdy_i = '1;
        set_in(2, 1'b1, 4, 8'hA5);
        #1;
        checks++;
        if (rdy_o !== 5'b00100) begin
            errs++;
            $display("FAIL single_rdy: got %b expected %b", rdy_o, 5'b00100);
        end
        tick();
        checks++;
        if (out_data(4) !== 8'hA5 || vld_o !== 5'b10000) begin
            errs++;
            $display("FAIL single_out: got data=%h vld=%b expected data=a5 vld=10000", out_data(4), vld_o);
        end
        clear_in();
        tick();
        checks++;
        if (vld_o !== 5'b00000) begin
            errs++;
            $display("FAIL single_drain: got vld=%b expected 00000", vld_o);
        end
    endtask

    task automatic test_permutation();
        clear_in();
        rdy_i = '1;
        for (int k = 0; k < N; k++) set_in(k, 1'b1, (k + 1) % N, 8'(8'h10 + k));
        #1;
        checks++;
        if (rdy_o !== 5'b11111) begin
            errs++;
            $display("FAIL perm_rdy: got %b expected 11111", rdy_o);
        end
        tick();
        for (int j = 0; j < N; j++) begin
            logic [DW-1:0] e;
            e = 8'(8'h10 + (j + N - 1) % N);
            checks++;
            if (out_data(j) !== e) begin
                errs++;
                $display("FAIL perm_data%0d: got %h expected %h", j, out_data(j), e);
            end
        end
        checks++;
        if (vld_o !== 5'b11111) begin
            errs++;
            $display("FAIL perm_vld: got %b expected 11111", vld_o);
        end
        clear_in();
        tick();
    endtask

    task automatic test_fairness();
        int exp_seq [6];
        exp_seq = '{0, 1, 3, 0, 1, 3};
        do_reset();
        rdy_i = '1;
        set_in(0, 1'b1, 2, 8'h30);
        set_in(1, 1'b1, 2, 8'h31);
        set_in(3, 1'b1, 2, 8'h33);
        for (int c = 0; c < 6; c++) begin
            logic [N-1:0] e;
            e = '0;
            e[exp_seq[c]] = 1'b1;
            #1;
            checks++;
            if (rdy_o !== e) begin
                errs++;
                $display("FAIL fair_grant%0d: got %b expected %b", c, rdy_o, e);
            end
            tick();
            checks++;
            if (vld_o[2] !== 1'b1 || out_data(2) !== 8'(8'h30 + exp_seq[c])) begin
                errs++;
                $display("FAIL fair_out%0d: got vld=%b data=%h expected vld=1 data=%h",
                         c, vld_o[2], out_data(2), 8'(8'h30 + exp_seq[c]));
            end
        end
        clear_in();
        tick();
    endtask

    task automatic test_backpressure();
        clear_in();
        rdy_i = '1;
        set_in(0, 1'b1, 1, 8'h55);
        tick();
        set_in(0, 1'b1, 1, 8'h66);
        rdy_i[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (rdy_o[0] !== 1'b0) begin
                errs++;
                $display("FAIL bp_rdy%0d: got %b expected 0", c, rdy_o[0]);
            end
            tick();
            checks++;
            if (out_data(1) !== 8'h55 || vld_o[1] !== 1'b1) begin
                errs++;
                $display("FAIL bp_hold%0d: got data=%h vld=%b expected data=55 vld=1", c, out_data(1), vld_o[1]);
            end
        end
        rdy_i[1] = 1'b1;
        #1;
        checks++;
        if (rdy_o[0] !== 1'b1) begin
            errs++;
            $display("FAIL bp_release: got %b expected 1", rdy_o[0]);
        end
        tick();
        checks++;
        if (out_data(1) !== 8'h66 || vld_o[1] !== 1'b1) begin
            errs++;
            $display("FAIL bp_newflit: got data=%h vld=%b expected data=66 vld=1", out_data(1), vld_o[1]);
        end
        clear_in();
        tick();
    endtask

    task automatic test_illegal_dst();
        logic [N-1:0] prev;
        clear_in();
        rdy_i = '1;
        tick();
        prev = vld_o;
        set_in(3, 1'b1, 6, 8'hEE);
        #1;
        checks++;
        if (rdy_o !== 5'b01000) begin
            errs++;
            $display("FAIL drop_rdy: got %b expected 01000", rdy_o);
        end
        tick();
        checks++;
        if (drop_o !== 1'b1 || vld_o !== prev) begin
            errs++;
            $display("FAIL drop_pulse: got drop=%b vld=%b expected drop=1 vld=%b", drop_o, vld_o, prev);
        end
        clear_in();
        tick();
        checks++;
        if (drop_o !== 1'b0) begin
            errs++;
            $display("FAIL drop_clear: got %b expected 0", drop_o);
        end
    endtask

    task automatic test_reset_mid();
        clear_in();
        rdy_i = '1;
        set_in(1, 1'b1, 1, 8'h71);
        set_in(2, 1'b1, 2, 8'h72);
        tick();
        checks++;
        if (vld_o !== 5'b00110) begin
            errs++;
            $display("FAIL rmid_setup: got vld=%b expected 00110", vld_o);
        end
        clear_in();
        rdy_i = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy_o !== '0) begin
            errs++;
            $display("FAIL rmid_rdy: got %b expected 00000", rdy_o);
        end
        tick();
        rst_n = 1'b1;
        checks++;
        if (vld_o !== '0 || data_o !== '0) begin
            errs++;
            $display("FAIL rmid_clear: got vld=%b data=%h expected zero", vld_o, data_o);
        end
        rdy_i = '1;
        set_in(0, 1'b1, 2, 8'h80);
        set_in(1, 1'b1, 2, 8'h81);
        set_in(3, 1'b1, 2, 8'h83);
        #1;
        checks++;
        if (rdy_o !== 5'b00001) begin
            errs++;
            $display("FAIL rmid_first: got %b expected 00001", rdy_o);
        end
        tick();
        clear_in();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                int d;
                d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(N, 7)) : int'($urandom_range(0, N - 1));
                set_in(k, 1'(($urandom_range(0, 3) != 0)), d, 8'($urandom));
            end
            rdy_i = N'($urandom);
            if ($urandom_range(0, 3) == 0) rdy_i = '1;
            #1;
            m_arb();
            checks++;
            if (rdy_o !== m_rdy) begin
                errs++;
                $display("FAIL rand_rdy%0d: got %b expected %b", c, rdy_o, m_rdy);
            end
            tick();
            checks++;
            if (vld_o !== m_vld_vec() || data_o !== m_data_vec() || drop_o !== m_drop) begin
                errs++;
                $display("FAIL rand_out%0d: got vld=%b data=%h drop=%b expected vld=%b data=%h drop=%b",
                         c, vld_o, data_o, drop_o, m_vld_vec(), m_data_vec(), m_drop);
            end
        end
        clear_in();
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        rdy_i  = '1;
        clear_in();
        m_reset();
        test_reset();
        test_single_path();
        test_permutation();
        test_fairness();
        test_backpressure();
        test_illegal_dst();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
